mlp_seq_controller: RTL and testbench
=====================================

Name: mlp_seq_controller

Overview:
- Parametrised two-layer sequencer for the recursive MAC-array datapath.
- Layer 1 reads the input vector (din1) against weight rows (din2), one output column at a time, and writes each column result to the temp buffer.
- Layer 2 reads the temp buffer against din3 weights for L2_COLS output columns.
- Generalises dimensions and BRAM read latency, supports multiple layer-2 columns, re-arms after done, and supports abort.

Parameters:
- MAC_NUM, 8, MAC lanes per word.
- IN_ELEMS, 32, layer-1 input elements. Derived K1 = IN_ELEMS/MAC_NUM words per column; K1 >= 2.
- OUT_COLS, 8, layer-1 output columns. This is also the temp depth and the layer-2 words per column (K2); must be >= 2.
- L2_COLS, 1, layer-2 output columns; must be >= 1.
- RD_LAT, 1, BRAM read latency in cycles; range 1..4.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- abort_i  in  1  synchronous abort; effective in L1/L2.
- din1_addr_o  out  W1=max(1,clog2(K1))  input-vector address.
- din1_en_o  out  1  din1 read enable.
- din2_addr_o  out  clog2(OUT_COLS*K1)  layer-1 weight address.
- din2_en_o  out  1  din2 read enable.
- din3_addr_o  out  max(1,clog2(L2_COLS*OUT_COLS))  layer-2 weight address.
- din3_en_o  out  1  din3 read enable.
- temp_rd_en_o  out  1  temp buffer read enable.
- temp_wr_en_o  out  1  temp buffer write enable.
- temp_addr_o  out  clog2(OUT_COLS)  temp address: write address in L1, read address in L2.
- mux_ctrl_o  out  1  PU operand select: 0 = din1, 1 = temp.
- pu_en_o  out  1  MAC accumulate enable.
- pu_valid_o  out  1  column result valid.
- pu_clear_o  out  1  accumulator clear.
- busy_o  out  1  high in L1 and L2.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered. Reset, asynchronous on rst_i high, drives the state to IDLE and every output and counter to 0.
- States: IDLE, L1, L2, DONE.
  - IDLE -> L1 on start_i.
  - L1 -> L2 after the pu_clear of column OUT_COLS-1.
  - L2 -> DONE after the pu_clear of column L2_COLS-1.
  - DONE -> IDLE unconditionally after 1 cycle.
- start_i outside IDLE is ignored.
- Column slot, relative cycle s = 0 at the first issue cycle:
  - s = 0..K-1: issue. Enables are high with address index k = s.
  - s = RD_LAT..RD_LAT+K-1: pu_en_o = 1. This is the issue-enable delayed RD_LAT cycles through a shift register.
  - s = RD_LAT+K: pu_valid_o = 1 for one cycle.
  - s = RD_LAT+K+1: pu_clear_o = 1 for one cycle.
  - The next column's s = 0 follows immediately, so slot period P = K+RD_LAT+2.
- L1, column c, K = K1:
  - din1_en_o = din2_en_o = 1.
  - din1_addr_o = k; din2_addr_o = c*K1+k.
  - In the pu_valid cycle: temp_wr_en_o = 1 and temp_addr_o = c.
  - mux_ctrl_o = 0.
- L2, column j, K = OUT_COLS:
  - temp_rd_en_o = din3_en_o = 1.
  - temp_addr_o = k; din3_addr_o = j*OUT_COLS+k.
  - temp_wr_en_o = 0.
  - mux_ctrl_o = 1 from the first L2 issue cycle through the last L2 pu_clear.
- Timing:
  - The first L1 issue cycle is the first cycle with busy_o = 1, i.e. the cycle after start_i is sampled.
  - The first L2 issue cycle directly follows the last L1 clear cycle.
  - busy_o lasts OUT_COLS*(K1+RD_LAT+2) + L2_COLS*(OUT_COLS+RD_LAT+2) cycles. Default: 56+11 = 67.
  - done_o is high in the cycle after the last L2 clear, with busy_o = 0. The block then accepts a new start_i from the following IDLE cycle.
- Outside issue cycles, enables are 0. Addresses hold their last value except temp_addr_o, which carries the write address as above.
- abort_i in L1/L2:
  - Next cycle: state = IDLE, all enables/valid/wr_en/mux/busy = 0, pu_clear_o = 1 for one cycle, no done_o pulse.
  - Abort has priority over a slot transition in the same cycle.
  - abort_i is ignored in IDLE and DONE.
- Counters (slot phase, column index, pipeline shift register) wrap only through explicit reload; no arithmetic overflow is permitted.

Test Plan:
- Defaults, start_i pulse at cycle 0:
  - din1_addr sequence 0,1,2,3 per column; din2_addr 0..31 contiguous across columns.
  - pu_valid and temp_wr_en at slot s = 5 with temp_addr 0..7.
  - mux_ctrl rises at busy cycle 56.
  - din3_addr 0..7; single L2 pu_valid at busy cycle 56+9.
  - done_o at busy cycle 67, exactly one cycle.
- RD_LAT = 3, IN_ELEMS = 64 (K1 = 8):
  - pu_en lags enables by 3 cycles; P1 = 13.
  - busy duration 8*13 + 1*(8+3+2) = 117 cycles.
- L2_COLS = 3: din3_addr 0..7, 8..15, 16..23; three pu_valid/pu_clear pairs in L2; temp_addr read sequence repeats 0..7 three times.
- abort_i at busy cycle 20: next cycle busy_o = 0, all enables 0, pu_clear = 1 for one cycle, no done_o. A subsequent start_i reruns the full 67-cycle sequence.
- start_i held high across a complete run plus DONE: ignored while busy; the run restarts only in the IDLE cycle after DONE.
- rst_i asserted asynchronously mid-L2: all outputs 0 immediately, without waiting for a clock edge; after release, start_i yields a clean run.

Source files
------------

// File: rtl/mlp_seq_controller_if.sv
// Control/address bundle between the two-layer MLP sequencer and its BRAMs / MAC array.
interface mlp_seq_controller_if #(
    parameter int unsigned MAC_NUM  = 8,
    parameter int unsigned IN_ELEMS = 32,
    parameter int unsigned OUT_COLS = 8,
    parameter int unsigned L2_COLS  = 1
);
    localparam int unsigned K1 = IN_ELEMS / MAC_NUM;
    localparam int unsigned W1 = (K1 > 1) ? $clog2(K1) : 1;
    localparam int unsigned W2 = $clog2(OUT_COLS * K1);
    localparam int unsigned W3 = (L2_COLS * OUT_COLS > 1) ? $clog2(L2_COLS * OUT_COLS) : 1;
    localparam int unsigned WT = $clog2(OUT_COLS);

    logic          start_i;
    logic          abort_i;
    logic [W1-1:0] din1_addr_o;
    logic          din1_en_o;
    logic [W2-1:0] din2_addr_o;
    logic          din2_en_o;
    logic [W3-1:0] din3_addr_o;
    logic          din3_en_o;
    logic          temp_rd_en_o;
    logic          temp_wr_en_o;
    logic [WT-1:0] temp_addr_o;
    logic          mux_ctrl_o;
    logic          pu_en_o;
    logic          pu_valid_o;
    logic          pu_clear_o;
    logic          busy_o;
    logic          done_o;

    modport master (
        input  start_i, abort_i,
        output din1_addr_o, din1_en_o, din2_addr_o, din2_en_o, din3_addr_o, din3_en_o,
               temp_rd_en_o, temp_wr_en_o, temp_addr_o, mux_ctrl_o,
               pu_en_o, pu_valid_o, pu_clear_o, busy_o, done_o
    );

    modport slave (
        output start_i, abort_i,
        input  din1_addr_o, din1_en_o, din2_addr_o, din2_en_o, din3_addr_o, din3_en_o,
               temp_rd_en_o, temp_wr_en_o, temp_addr_o, mux_ctrl_o,
               pu_en_o, pu_valid_o, pu_clear_o, busy_o, done_o
    );
endinterface

// File: rtl/mlp_seq_controller.sv
// Two-layer MAC-array sequencer: layer 1 streams din1 x din2 into the temp buffer,
// layer 2 streams temp x din3 for L2_COLS columns. Every output is a flop.
module mlp_seq_controller #(
    parameter int unsigned MAC_NUM  = 8,
    parameter int unsigned IN_ELEMS = 32,
    parameter int unsigned OUT_COLS = 8,
    parameter int unsigned L2_COLS  = 1,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mlp_seq_controller_if.master bus
);
    localparam int unsigned K1   = IN_ELEMS / MAC_NUM;
    localparam int unsigned K2   = OUT_COLS;
    localparam int unsigned P1   = K1 + RD_LAT + 2;
    localparam int unsigned P2   = K2 + RD_LAT + 2;
    localparam int unsigned PMAX = (P1 > P2) ? P1 : P2;
    localparam int unsigned CMAX = (OUT_COLS > L2_COLS) ? OUT_COLS : L2_COLS;
    localparam int unsigned SW   = $clog2(PMAX);
    localparam int unsigned CW   = $clog2(CMAX);
    localparam int unsigned PW   = RD_LAT;
    localparam int unsigned W1   = (K1 > 1) ? $clog2(K1) : 1;
    localparam int unsigned W2   = $clog2(OUT_COLS * K1);
    localparam int unsigned W3   = (L2_COLS * OUT_COLS > 1) ? $clog2(L2_COLS * OUT_COLS) : 1;
    localparam int unsigned WT   = $clog2(OUT_COLS);

    localparam logic [SW-1:0] S1_LAST = SW'(P1 - 1);
    localparam logic [SW-1:0] S1_ISS  = SW'(K1);
    localparam logic [SW-1:0] S1_VAL  = SW'(K1 + RD_LAT);
    localparam logic [SW-1:0] S1_CLR  = SW'(K1 + RD_LAT + 1);
    localparam logic [SW-1:0] S2_LAST = SW'(P2 - 1);
    localparam logic [SW-1:0] S2_ISS  = SW'(K2);
    localparam logic [SW-1:0] S2_VAL  = SW'(K2 + RD_LAT);
    localparam logic [SW-1:0] S2_CLR  = SW'(K2 + RD_LAT + 1);
    localparam logic [CW-1:0] C1_LAST = CW'(OUT_COLS - 1);
    localparam logic [CW-1:0] C2_LAST = CW'(L2_COLS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_L1, ST_L2, ST_DONE} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] phase_q, phase_d;
    logic [CW-1:0] col_q, col_d;
    logic [PW-1:0] pipe_q, pipe_d;
    logic [W1-1:0] din1_addr_q, din1_addr_d;
    logic [W2-1:0] din2_addr_q, din2_addr_d;
    logic [W3-1:0] din3_addr_q, din3_addr_d;
    logic [WT-1:0] temp_addr_q, temp_addr_d;
    logic          din1_en_q, din1_en_d;
    logic          din2_en_q, din2_en_d;
    logic          din3_en_q, din3_en_d;
    logic          temp_rd_en_q, temp_rd_en_d;
    logic          temp_wr_en_q, temp_wr_en_d;
    logic          mux_ctrl_q, mux_ctrl_d;
    logic          pu_en_q, pu_en_d;
    logic          pu_valid_q, pu_valid_d;
    logic          pu_clear_q, pu_clear_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          issue;
    logic          abort_hit;

    // Next state first, then the outputs are decoded from the next state so they land registered.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        col_d        = col_q;
        pipe_d       = '0;
        din1_addr_d  = din1_addr_q;
        din2_addr_d  = din2_addr_q;
        din3_addr_d  = din3_addr_q;
        temp_addr_d  = temp_addr_q;
        din1_en_d    = 1'b0;
        din2_en_d    = 1'b0;
        din3_en_d    = 1'b0;
        temp_rd_en_d = 1'b0;
        temp_wr_en_d = 1'b0;
        mux_ctrl_d   = 1'b0;
        pu_en_d      = 1'b0;
        pu_valid_d   = 1'b0;
        pu_clear_d   = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        issue        = 1'b0;
        abort_hit    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_L1;
                    phase_d = '0;
                    col_d   = '0;
                end
            end
            ST_L1: begin
                if (bus.abort_i) begin
                    state_d   = ST_IDLE;
                    abort_hit = 1'b1;
                end else if (phase_q == S1_LAST) begin
                    phase_d = '0;
                    if (col_q == C1_LAST) begin
                        state_d = ST_L2;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    phase_d = phase_q + SW'(1);
                end
            end
            ST_L2: begin
                if (bus.abort_i) begin
                    state_d   = ST_IDLE;
                    abort_hit = 1'b1;
                end else if (phase_q == S2_LAST) begin
                    phase_d = '0;
                    if (col_q == C2_LAST) begin
                        state_d = ST_DONE;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    phase_d = phase_q + SW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_L1: begin
                busy_d = 1'b1;
                if (phase_d < S1_ISS) begin
                    issue       = 1'b1;
                    din1_en_d   = 1'b1;
                    din2_en_d   = 1'b1;
                    din1_addr_d = W1'(phase_d);
                    din2_addr_d = W2'(int'(col_d) * int'(K1) + int'(phase_d));
                end
                if (phase_d == S1_VAL) begin
                    pu_valid_d   = 1'b1;
                    temp_wr_en_d = 1'b1;
                    temp_addr_d  = WT'(col_d);
                end
                if (phase_d == S1_CLR) pu_clear_d = 1'b1;
            end
            ST_L2: begin
                busy_d     = 1'b1;
                mux_ctrl_d = 1'b1;
                if (phase_d < S2_ISS) begin
                    issue        = 1'b1;
                    temp_rd_en_d = 1'b1;
                    din3_en_d    = 1'b1;
                    temp_addr_d  = WT'(phase_d);
                    din3_addr_d  = W3'(int'(col_d) * int'(K2) + int'(phase_d));
                end
                if (phase_d == S2_VAL) pu_valid_d = 1'b1;
                if (phase_d == S2_CLR) pu_clear_d = 1'b1;
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase

        // Issue enable delayed RD_LAT cycles to line up with BRAM read data.
        if (state_d == ST_L1 || state_d == ST_L2) begin
            pipe_d  = PW'({pipe_q, issue});
            pu_en_d = pipe_q[PW-1];
        end

        if (abort_hit) pu_clear_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            col_q        <= '0;
            pipe_q       <= '0;
            din1_addr_q  <= '0;
            din2_addr_q  <= '0;
            din3_addr_q  <= '0;
            temp_addr_q  <= '0;
            din1_en_q    <= 1'b0;
            din2_en_q    <= 1'b0;
            din3_en_q    <= 1'b0;
            temp_rd_en_q <= 1'b0;
            temp_wr_en_q <= 1'b0;
            mux_ctrl_q   <= 1'b0;
            pu_en_q      <= 1'b0;
            pu_valid_q   <= 1'b0;
            pu_clear_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            col_q        <= col_d;
            pipe_q       <= pipe_d;
            din1_addr_q  <= din1_addr_d;
            din2_addr_q  <= din2_addr_d;
            din3_addr_q  <= din3_addr_d;
            temp_addr_q  <= temp_addr_d;
            din1_en_q    <= din1_en_d;
            din2_en_q    <= din2_en_d;
            din3_en_q    <= din3_en_d;
            temp_rd_en_q <= temp_rd_en_d;
            temp_wr_en_q <= temp_wr_en_d;
            mux_ctrl_q   <= mux_ctrl_d;
            pu_en_q      <= pu_en_d;
            pu_valid_q   <= pu_valid_d;
            pu_clear_q   <= pu_clear_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.din1_addr_o  = din1_addr_q;
    assign bus.din1_en_o    = din1_en_q;
    assign bus.din2_addr_o  = din2_addr_q;
    assign bus.din2_en_o    = din2_en_q;
    assign bus.din3_addr_o  = din3_addr_q;
    assign bus.din3_en_o    = din3_en_q;
    assign bus.temp_rd_en_o = temp_rd_en_q;
    assign bus.temp_wr_en_o = temp_wr_en_q;
    assign bus.temp_addr_o  = temp_addr_q;
    assign bus.mux_ctrl_o   = mux_ctrl_q;
    assign bus.pu_en_o      = pu_en_q;
    assign bus.pu_valid_o   = pu_valid_q;
    assign bus.pu_clear_o   = pu_clear_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
endmodule

// File: tb/tb_mlp_seq_controller.sv
// Scoreboard bench for mlp_seq_controller: three parameterisations, expected output
// events queued at stimulus time and popped by per-DUT monitors on the falling edge.
module tb_mlp_seq_controller;
    typedef struct packed {
        int cyc;
        int kind;
        int val;
    } ev_t;

    localparam int NOSTOP = 1 << 30;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[3][$];
    bit   prev_busy[3] = '{0, 0, 0};
    bit   prev_mux[3]  = '{0, 0, 0};

    mlp_seq_controller_if #(.MAC_NUM(8), .IN_ELEMS(32), .OUT_COLS(8), .L2_COLS(1)) bus0 ();
    mlp_seq_controller_if #(.MAC_NUM(8), .IN_ELEMS(64), .OUT_COLS(8), .L2_COLS(1)) bus1 ();
    mlp_seq_controller_if #(.MAC_NUM(8), .IN_ELEMS(32), .OUT_COLS(8), .L2_COLS(3)) bus2 ();

    mlp_seq_controller #(.MAC_NUM(8), .IN_ELEMS(32), .OUT_COLS(8), .L2_COLS(1), .RD_LAT(1))
        dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
    mlp_seq_controller #(.MAC_NUM(8), .IN_ELEMS(64), .OUT_COLS(8), .L2_COLS(1), .RD_LAT(3))
        dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
    mlp_seq_controller #(.MAC_NUM(8), .IN_ELEMS(32), .OUT_COLS(8), .L2_COLS(3), .RD_LAT(1))
        dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            1: return "busy_edge";
            2: return "mux_edge";
            3: return "l1_read";
            4: return "l2_read";
            5: return "pu_en";
            6: return "pu_valid";
            7: return "pu_clear";
            8: return "done";
            default: return "stray_temp_wr";
        endcase
    endfunction

    task automatic push(input int id, input int c, input int k, input int v);
        ev_t e;
        e.cyc = c; e.kind = k; e.val = v;
        exp_q[id].push_back(e);
    endtask

    task automatic take(input int id, input int c, input int k, input int v);
        ev_t e;
        checks++;
        if (exp_q[id].size() == 0) begin
            errors++;
            $display("FAIL dut%0d unexpected %s at cyc %0d val %h", id, kname(k), c, v);
            return;
        end
        e = exp_q[id].pop_front();
        if (e.cyc != c || e.kind != k || e.val != v) begin
            errors++;
            $display("FAIL dut%0d %s: got cyc %0d val %h, expected %s at cyc %0d val %h",
                     id, kname(k), c, v, kname(e.kind), e.cyc, e.val);
        end
    endtask

    // Observed event order per cycle must match the order gen() pushes them.
    task automatic mon(input int id, input int c, input logic [10:0] f,
                       input int a1, input int a2, input int a3, input int ta);
        if (f[9] != prev_busy[id]) take(id, c, 1, int'(f[9]));
        if (f[5] != prev_mux[id])  take(id, c, 2, int'(f[5]));
        prev_busy[id] = f[9];
        prev_mux[id]  = f[5];
        if (f[0] | f[1]) take(id, c, 3, (int'(f[0]) << 25) | (int'(f[1]) << 24) | (a1 << 12) | a2);
        if (f[3] | f[2]) take(id, c, 4, (int'(f[3]) << 25) | (int'(f[2]) << 24) | (ta << 12) | a3);
        if (f[6]) take(id, c, 5, 0);
        if (f[7]) take(id, c, 6, f[4] ? ((1 << 16) | ta) : 0);
        if (f[4] && !f[7]) take(id, c, 9, ta);
        if (f[8]) take(id, c, 7, int'(f[9]));
        if (f[10]) take(id, c, 8, int'(f[9]));
    endtask

    always @(negedge clk)
        mon(0, cyc, {bus0.done_o, bus0.busy_o, bus0.pu_clear_o, bus0.pu_valid_o, bus0.pu_en_o,
                     bus0.mux_ctrl_o, bus0.temp_wr_en_o, bus0.temp_rd_en_o, bus0.din3_en_o,
                     bus0.din2_en_o, bus0.din1_en_o},
            int'(bus0.din1_addr_o), int'(bus0.din2_addr_o), int'(bus0.din3_addr_o), int'(bus0.temp_addr_o));
    always @(negedge clk)
        mon(1, cyc, {bus1.done_o, bus1.busy_o, bus1.pu_clear_o, bus1.pu_valid_o, bus1.pu_en_o,
                     bus1.mux_ctrl_o, bus1.temp_wr_en_o, bus1.temp_rd_en_o, bus1.din3_en_o,
                     bus1.din2_en_o, bus1.din1_en_o},
            int'(bus1.din1_addr_o), int'(bus1.din2_addr_o), int'(bus1.din3_addr_o), int'(bus1.temp_addr_o));
    always @(negedge clk)
        mon(2, cyc, {bus2.done_o, bus2.busy_o, bus2.pu_clear_o, bus2.pu_valid_o, bus2.pu_en_o,
                     bus2.mux_ctrl_o, bus2.temp_wr_en_o, bus2.temp_rd_en_o, bus2.din3_en_o,
                     bus2.din2_en_o, bus2.din1_en_o},
            int'(bus2.din1_addr_o), int'(bus2.din2_addr_o), int'(bus2.din3_addr_o), int'(bus2.temp_addr_o));

    // Expected event stream of one run whose first busy cycle is b; events stop before stop_rel.
    task automatic gen(input int id, input int b, input int k1, input int oc, input int l2c,
                       input int rl, input int stop_rel);
        int p1, p2, l1t, tot;
        p1 = k1 + rl + 2;
        p2 = oc + rl + 2;
        l1t = oc * p1;
        tot = l1t + l2c * p2;
        for (int rel = 0; rel <= tot && rel < stop_rel; rel++) begin
            int s, c, k, t;
            s = 0; c = 0; k = 0; t = b + rel;
            if (rel == 0)   push(id, t, 1, 1);
            if (rel == tot) push(id, t, 1, 0);
            if (rel == l1t) push(id, t, 2, 1);
            if (rel == tot) push(id, t, 2, 0);
            if (rel < l1t) begin
                c = rel / p1; s = rel % p1; k = k1;
                if (s < k1) push(id, t, 3, (3 << 24) | (s << 12) | (c * k1 + s));
            end else if (rel < tot) begin
                c = (rel - l1t) / p2; s = (rel - l1t) % p2; k = oc;
                if (s < oc) push(id, t, 4, (3 << 24) | (s << 12) | (c * oc + s));
            end
            if (rel < tot) begin
                if (s >= rl && s < rl + k) push(id, t, 5, 0);
                if (s == rl + k) push(id, t, 6, (rel < l1t) ? ((1 << 16) | c) : 0);
                if (s == rl + k + 1) push(id, t, 7, 1);
            end
            if (rel == tot) push(id, t, 8, 0);
        end
    endtask

    task automatic check_eq(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int id, input int budget);
        int n;
        n = 0;
        while (exp_q[id].size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq($sformatf("dut%0d_pending_events", id), exp_q[id].size(), 0);
        exp_q[id].delete();
        repeat (5) @(posedge clk);
        #1;
    endtask

    function automatic int flags0();
        return int'({bus0.done_o, bus0.busy_o, bus0.pu_clear_o, bus0.pu_valid_o, bus0.pu_en_o,
                     bus0.mux_ctrl_o, bus0.temp_wr_en_o, bus0.temp_rd_en_o, bus0.din3_en_o,
                     bus0.din2_en_o, bus0.din1_en_o});
    endfunction
    function automatic int flags1();
        return int'({bus1.done_o, bus1.busy_o, bus1.pu_clear_o, bus1.pu_valid_o, bus1.pu_en_o,
                     bus1.mux_ctrl_o, bus1.temp_wr_en_o, bus1.temp_rd_en_o, bus1.din3_en_o,
                     bus1.din2_en_o, bus1.din1_en_o});
    endfunction
    function automatic int flags2();
        return int'({bus2.done_o, bus2.busy_o, bus2.pu_clear_o, bus2.pu_valid_o, bus2.pu_en_o,
                     bus2.mux_ctrl_o, bus2.temp_wr_en_o, bus2.temp_rd_en_o, bus2.din3_en_o,
                     bus2.din2_en_o, bus2.din1_en_o});
    endfunction
    function automatic int addrs2();
        return int'(bus2.din1_addr_o) + int'(bus2.din2_addr_o) + int'(bus2.din3_addr_o) + int'(bus2.temp_addr_o);
    endfunction

    initial begin
        int b;
        clk = 1'b0;
        rst = 1'b1;
        bus0.start_i = 1'b0; bus0.abort_i = 1'b0;
        bus1.start_i = 1'b0; bus1.abort_i = 1'b0;
        bus2.start_i = 1'b0; bus2.abort_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_flags_dut0", flags0(), 0);
        check_eq("reset_flags_dut1", flags1(), 0);
        check_eq("reset_flags_dut2", flags2(), 0);
        check_eq("reset_addr_dut0", int'(bus0.din1_addr_o) + int'(bus0.din2_addr_o)
                 + int'(bus0.din3_addr_o) + int'(bus0.temp_addr_o), 0);
        check_eq("reset_addr_dut2", addrs2(), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Default configuration, single start pulse
        b = cyc + 1;
        gen(0, b, 4, 8, 1, 1, NOSTOP);
        bus0.start_i = 1'b1; @(posedge clk); #1; bus0.start_i = 1'b0;
        wait_drain(0, 200);

        // RD_LAT = 3, K1 = 8
        b = cyc + 1;
        gen(1, b, 8, 8, 1, 3, NOSTOP);
        bus1.start_i = 1'b1; @(posedge clk); #1; bus1.start_i = 1'b0;
        wait_drain(1, 300);

        // Three layer-2 columns
        b = cyc + 1;
        gen(2, b, 4, 8, 3, 1, NOSTOP);
        bus2.start_i = 1'b1; @(posedge clk); #1; bus2.start_i = 1'b0;
        wait_drain(2, 300);

        // Abort during busy cycle 20, then a full rerun
        b = cyc + 1;
        gen(0, b, 4, 8, 1, 1, 21);
        push(0, b + 21, 1, 0);
        push(0, b + 21, 7, 0);
        bus0.start_i = 1'b1; @(posedge clk); #1; bus0.start_i = 1'b0;
        wait_cyc(b + 20);
        bus0.abort_i = 1'b1; @(posedge clk); #1; bus0.abort_i = 1'b0;
        wait_drain(0, 50);
        b = cyc + 1;
        gen(0, b, 4, 8, 1, 1, NOSTOP);
        bus0.start_i = 1'b1; @(posedge clk); #1; bus0.start_i = 1'b0;
        wait_drain(0, 200);

        // start held through a run and DONE: second run begins after the IDLE cycle
        b = cyc + 1;
        gen(0, b, 4, 8, 1, 1, NOSTOP);
        gen(0, b + 69, 4, 8, 1, 1, NOSTOP);
        bus0.start_i = 1'b1;
        wait_cyc(b + 69);
        bus0.start_i = 1'b0;
        wait_drain(0, 300);

        // Asynchronous reset in the middle of layer 2, then a clean run
        b = cyc + 1;
        gen(2, b, 4, 8, 3, 1, 71);
        push(2, b + 71, 1, 0);
        push(2, b + 71, 2, 0);
        bus2.start_i = 1'b1; @(posedge clk); #1; bus2.start_i = 1'b0;
        wait_cyc(b + 71);
        #1;
        rst = 1'b1;
        #1;
        check_eq("async_rst_flags_dut2", flags2(), 0);
        check_eq("async_rst_addr_dut2", addrs2(), 0);
        wait_drain(2, 10);
        rst = 1'b0;
        @(posedge clk); #1;
        b = cyc + 1;
        gen(2, b, 4, 8, 3, 1, NOSTOP);
        bus2.start_i = 1'b1; @(posedge clk); #1; bus2.start_i = 1'b0;
        wait_drain(2, 300);

        check_eq("idle_flags_dut1", flags1(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
